instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_WIDTH SHALL be 64 by default and set the width of every PC and address in the block.
REQ-002 Parameter RESET_PC SHALL be 64'h0 by default and set the first fetch address after reset.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 resetN  in  1  asynchronous, active-low reset.
REQ-005 imemReq  out  1  one-cycle fetch request pulse to the instruction cache.
REQ-006 imemAddr  out  ADDR_WIDTH  byte address of the request; valid while imemReq=1.
REQ-007 imemValid  in  1  response strobe, 1 or more cycles after imemReq.
REQ-008 imemData  in  32  instruction word; valid while imemValid=1.
REQ-009 instruction  out  32  fetched instruction word presented to the Processor decode.
REQ-010 instrPC  out  ADDR_WIDTH  address of the presented instruction.
REQ-011 instrValid  out  1  instruction/instrPC are valid.
REQ-012 instrReady  in  1  decode accepts; a transfer occurs when instrValid=1 and instrReady=1.
REQ-013 branchFlag  in  1  conditional branch (CBZ) resolved this cycle.
REQ-014 unconditionalBranchFlag  in  1  B resolved this cycle.
REQ-015 zeroFlag  in  1  ALU zero result for CBZ.
REQ-016 branchPC  in  ADDR_WIDTH  PC of the resolving branch.
REQ-017 branchOffset  in  ADDR_WIDTH  sign-extended word offset of the branch.

Function
REQ-018 The fetch unit SHALL use FSM states IDLE, REQ, WAIT, FULL and DRAIN.
REQ-019 Redirect taken SHALL be computed combinationally as unconditionalBranchFlag OR (branchFlag AND zeroFlag).
REQ-020 Target SHALL equal branchPC + (branchOffset << 2), modulo 2^ADDR_WIDTH.
REQ-021 IDLE SHALL move to REQ one cycle after reset release.
REQ-022 REQ SHALL drive imemReq=1 and imemAddr=pc for exactly one cycle, then move to WAIT.
REQ-023 WAIT with imemValid=1 SHALL, on the next edge, load instruction=imemData and instrPC=pc, set instrValid=1, set pc=pc+4 (wrapping modulo 2^ADDR_WIDTH), and move to FULL.
REQ-024 FULL SHALL hold instruction and instrPC stable and instrValid=1 until a transfer occurs, then clear instrValid and move to REQ.
REQ-025 At most one request SHALL be outstanding; imemReq SHALL never be asserted in WAIT, FULL or DRAIN.
REQ-026 A taken redirect in IDLE or FULL SHALL set pc=target, clear instrValid, and move to REQ.
REQ-027 A taken redirect in REQ or WAIT SHALL set pc=target, clear instrValid, and move to DRAIN.
REQ-028 DRAIN SHALL discard the outstanding response on imemValid and then move to REQ.
REQ-029 A redirect takes priority over a simultaneous transfer; the transfer still counts as complete at decode.
REQ-030 A redirect and imemValid in the same WAIT cycle SHALL discard the response and move to REQ.
REQ-031 imemValid in IDLE, REQ or FULL SHALL be ignored.
REQ-032 Best-case latency SHALL be three cycles per instruction (REQ, WAIT, FULL) with a one-cycle memory and instrReady held at 1.

Reset
REQ-033 While resetN=0, the block SHALL force state=IDLE, pc=RESET_PC, imemReq=0, imemAddr=0, instruction=0, instrPC=0 and instrValid=0.
REQ-034 Reset mid-operation SHALL abandon any outstanding request.
REQ-035 A late response arriving after reset SHALL be ignored under REQ-031.

Structure
REQ-036 A shared package fetch_pkg SHALL hold the FSM state enum and the constants INSTR_WIDTH=32, ADDR_WIDTH=64 and PC_STEP=4.
REQ-037 A single sub-module branch_target SHALL compute the redirect-taken signal and the target address combinationally.

Verification
REQ-038 Reset release, 1-cycle memory returning 32'h8B150289 at address 0, instrReady=1 -> instruction=32'h8B150289, instrPC=0, next imemAddr=4.
REQ-039 instrReady=0 for 5 cycles while FULL -> instruction and instrPC stable, instrValid=1, imemReq=0 throughout.
REQ-040 unconditionalBranchFlag=1, branchPC=8, branchOffset=2 while FULL -> instrValid=0 next cycle, next imemAddr=16.
REQ-041 branchFlag=1, zeroFlag=0 -> no redirect; fetch continues sequentially at pc+4.
REQ-042 3-cycle memory, CBZ taken (zeroFlag=1, branchPC=0x20, branchOffset=-2) during WAIT -> stale response discarded, next imemAddr=0x18, no stale instrValid.
REQ-043 resetN=0 asserted during WAIT and released before the response arrives -> all outputs 0, late imemValid ignored, first request to RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared state encoding and sizing constants for the instruction fetch unit.
package fetch_pkg;

   localparam int unsigned INSTR_WIDTH = 32;
   localparam int unsigned ADDR_WIDTH  = 64;
   localparam int unsigned PC_STEP     = 4;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      FULL,
      DRAIN
   } fetch_state_e;

endpackage

// File: rtl/branch_target.sv
// Resolves whether a branch redirects fetch and where it goes.
module branch_target #(
   parameter int unsigned ADDR_WIDTH = fetch_pkg::ADDR_WIDTH
) (
   input  logic                  branch_flag,
   input  logic                  uncond_branch_flag,
   input  logic                  zero_flag,
   input  logic [ADDR_WIDTH-1:0] branch_pc,
   input  logic [ADDR_WIDTH-1:0] branch_offset,
   output logic                  taken,
   output logic [ADDR_WIDTH-1:0] target
);

   always_comb begin
      taken  = uncond_branch_flag | (branch_flag & zero_flag);
      // Offset counts words; the sum wraps naturally at ADDR_WIDTH bits.
      target = branch_pc + (branch_offset << 2);
   end

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding-request fetch unit feeding decode through a valid/ready slot,
// with branch redirects that drain any in-flight instruction-cache response.
module instruction_fetch #(
   parameter int unsigned           ADDR_WIDTH = fetch_pkg::ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                             clock,
   input  logic                             resetN,
   output logic                             imemReq,
   output logic [ADDR_WIDTH-1:0]            imemAddr,
   input  logic                             imemValid,
   input  logic [fetch_pkg::INSTR_WIDTH-1:0] imemData,
   output logic [fetch_pkg::INSTR_WIDTH-1:0] instruction,
   output logic [ADDR_WIDTH-1:0]            instrPC,
   output logic                             instrValid,
   input  logic                             instrReady,
   input  logic                             branchFlag,
   input  logic                             unconditionalBranchFlag,
   input  logic                             zeroFlag,
   input  logic [ADDR_WIDTH-1:0]            branchPC,
   input  logic [ADDR_WIDTH-1:0]            branchOffset
);

   import fetch_pkg::*;

   fetch_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
   logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]    instr_pc_q, instr_pc_d;
   logic                     instr_valid_q, instr_valid_d;
   logic                     redirect;
   logic [ADDR_WIDTH-1:0]    target;

   branch_target #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_branch_target (
      .branch_flag       (branchFlag),
      .uncond_branch_flag(unconditionalBranchFlag),
      .zero_flag         (zeroFlag),
      .branch_pc         (branchPC),
      .branch_offset     (branchOffset),
      .taken             (redirect),
      .target            (target)
   );

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      unique case (state_q)
         IDLE: begin
            state_d = REQ;
            if (redirect) pc_d = target;
         end
         REQ: begin
            if (redirect) begin
               pc_d    = target;
               state_d = DRAIN;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A response landing with the redirect is already the one to drop.
            if (redirect) begin
               pc_d    = target;
               state_d = imemValid ? REQ : DRAIN;
            end else if (imemValid) begin
               instr_d       = imemData;
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               pc_d          = pc_q + ADDR_WIDTH'(PC_STEP);
               state_d       = FULL;
            end
         end
         FULL: begin
            if (redirect) begin
               pc_d          = target;
               instr_valid_d = 1'b0;
               state_d       = REQ;
            end else if (instrReady) begin
               instr_valid_d = 1'b0;
               state_d       = REQ;
            end
         end
         DRAIN: begin
            if (redirect) pc_d = target;
            if (imemValid) state_d = REQ;
         end
         default: begin
            state_d       = IDLE;
            instr_valid_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      imemReq     = (state_q == REQ);
      imemAddr    = (state_q == REQ) ? pc_q : '0;
      instruction = instr_q;
      instrPC     = instr_pc_q;
      instrValid  = instr_valid_q;
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a behavioural instruction memory with
// programmable latency, request/transfer scoreboards and a few direct checks.
module tb_instruction_fetch;

   logic        clock;
   logic        resetN;
   logic        imemReq;
   logic [63:0] imemAddr;
   logic        imemValid;
   logic [31:0] imemData;
   logic [31:0] instruction;
   logic [63:0] instrPC;
   logic        instrValid;
   logic        instrReady;
   logic        branchFlag;
   logic        unconditionalBranchFlag;
   logic        zeroFlag;
   logic [63:0] branchPC;
   logic [63:0] branchOffset;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = -100;
   int          mem_lat = 1;
   logic        mem_busy;
   int          mem_cnt;
   logic [63:0] mem_addr;

   logic [63:0] exp_req[$];
   logic [95:0] exp_instr[$];
   int          req_times[$];

   instruction_fetch #(
      .ADDR_WIDTH(64),
      .RESET_PC  (64'h0)
   ) dut (
      .clock                  (clock),
      .resetN                 (resetN),
      .imemReq                (imemReq),
      .imemAddr               (imemAddr),
      .imemValid              (imemValid),
      .imemData               (imemData),
      .instruction            (instruction),
      .instrPC                (instrPC),
      .instrValid             (instrValid),
      .instrReady             (instrReady),
      .branchFlag             (branchFlag),
      .unconditionalBranchFlag(unconditionalBranchFlag),
      .zeroFlag               (zeroFlag),
      .branchPC               (branchPC),
      .branchOffset           (branchOffset)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == 64'h0) return 32'h8B150289;
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clock);
         #1;
         cyc++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_imemReq"},    64'(imemReq),     64'h0);
      check({tag, "_imemAddr"},   imemAddr,         64'h0);
      check({tag, "_instruction"}, 64'(instruction), 64'h0);
      check({tag, "_instrPC"},    instrPC,          64'h0);
      check({tag, "_instrValid"}, 64'(instrValid),  64'h0);
   endtask

   // Instruction memory: captures a request, answers after mem_lat cycles.
   initial begin
      imemValid = 1'b0;
      imemData  = '0;
      mem_busy  = 1'b0;
      mem_cnt   = 0;
      mem_addr  = '0;
      forever begin
         @(negedge clock);
         if (imemReq) begin
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = imemAddr;
         end
         @(posedge clock);
         #1;
         imemValid = 1'b0;
         imemData  = '0;
         if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               imemValid = 1'b1;
               imemData  = mem_word(mem_addr);
               mem_busy  = 1'b0;
            end
         end
      end
   end

   // Monitor: every request and every decode transfer is matched in order.
   always @(negedge clock) begin
      logic [63:0] ea;
      logic [95:0] ei;
      if (imemReq) begin
         req_times.push_back(cyc);
         if (exp_req.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_req @cyc %0d: got addr %h expected no request", cyc, imemAddr);
         end else begin
            ea = exp_req.pop_front();
            check("req_addr", imemAddr, ea);
         end
      end
      if (instrValid && instrReady) begin
         if (exp_instr.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_xfer @cyc %0d: got pc %h expected no transfer", cyc, instrPC);
         end else begin
            ei = exp_instr.pop_front();
            check("xfer_instr", 64'(instruction), 64'(ei[95:64]));
            check("xfer_pc",    instrPC,          ei[63:0]);
         end
      end
   end

   initial begin
      resetN                  = 1'b0;
      instrReady              = 1'b1;
      branchFlag              = 1'b0;
      unconditionalBranchFlag = 1'b0;
      zeroFlag                = 1'b0;
      branchPC                = '0;
      branchOffset            = '0;

      repeat (2) @(posedge clock);
      @(negedge clock);
      check_reset_outputs("rst");

      exp_req.push_back(64'h0);
      exp_req.push_back(64'h4);
      exp_req.push_back(64'h8);
      exp_instr.push_back({32'h8B150289, 64'h0});
      exp_instr.push_back({mem_word(64'h4), 64'h4});
      @(posedge clock);
      #1;
      resetN = 1'b1;
      cyc    = 0;

      // Decode stalls on the instruction at 8.
      goto(7);
      instrReady = 1'b0;
      goto(9);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("stall_valid", 64'(instrValid),  64'h1);
         check("stall_instr", 64'(instruction), 64'(mem_word(64'h8)));
         check("stall_pc",    instrPC,          64'h8);
         check("stall_noreq", 64'(imemReq),     64'h0);
         goto(cyc + 1);
      end

      // B while FULL and stalled: 8 + (2<<2) = 16.
      exp_req.push_back(64'h10);
      unconditionalBranchFlag = 1'b1;
      branchPC                = 64'h8;
      branchOffset            = 64'h2;
      goto(15);
      unconditionalBranchFlag = 1'b0;
      instrReady              = 1'b1;
      @(negedge clock);
      check("b_full_clr_valid", 64'(instrValid), 64'h0);

      // CBZ not taken during a transfer: sequential fetch continues.
      exp_instr.push_back({mem_word(64'h10), 64'h10});
      exp_req.push_back(64'h14);
      goto(17);
      branchFlag   = 1'b1;
      zeroFlag     = 1'b0;
      branchPC     = 64'h200;
      branchOffset = 64'h4;
      goto(18);
      branchFlag = 1'b0;

      // Redirect coinciding with a transfer: transfer still counts.
      exp_instr.push_back({mem_word(64'h14), 64'h14});
      exp_req.push_back(64'h140);
      goto(20);
      unconditionalBranchFlag = 1'b1;
      branchPC                = 64'h100;
      branchOffset            = 64'h10;
      goto(21);
      unconditionalBranchFlag = 1'b0;
      mem_lat                 = 3;

      // CBZ taken during WAIT with a 3-cycle memory: 0x20 - 8 = 0x18.
      exp_req.push_back(64'h18);
      goto(22);
      branchFlag   = 1'b1;
      zeroFlag     = 1'b1;
      branchPC     = 64'h20;
      branchOffset = -64'sd2;
      goto(23);
      branchFlag = 1'b0;
      zeroFlag   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("drain_no_valid", 64'(instrValid), 64'h0);
         goto(cyc + 1);
      end

      // Redirect and response in the same WAIT cycle: 0x40 + 4 = 0x44.
      exp_instr.push_back({mem_word(64'h18), 64'h18});
      exp_req.push_back(64'h1C);
      exp_req.push_back(64'h44);
      goto(33);
      unconditionalBranchFlag = 1'b1;
      branchPC                = 64'h40;
      branchOffset            = 64'h1;
      goto(34);
      unconditionalBranchFlag = 1'b0;
      mem_lat                 = 1;
      @(negedge clock);
      check("wait_hit_no_valid", 64'(instrValid), 64'h0);

      // Redirect in REQ: the issued request's response is drained.
      exp_instr.push_back({mem_word(64'h44), 64'h44});
      exp_req.push_back(64'h48);
      exp_req.push_back(64'h80);
      goto(37);
      unconditionalBranchFlag = 1'b1;
      branchPC                = 64'h80;
      branchOffset            = 64'h0;
      goto(38);
      unconditionalBranchFlag = 1'b0;

      // Reset during WAIT; the late response lands while IDLE.
      exp_instr.push_back({mem_word(64'h80), 64'h80});
      exp_req.push_back(64'h84);
      goto(42);
      mem_lat = 3;
      goto(44);
      resetN = 1'b0;
      @(negedge clock);
      check_reset_outputs("midrst");
      exp_req.push_back(64'h0);
      exp_req.push_back(64'h4);
      exp_instr.push_back({32'h8B150289, 64'h0});
      goto(45);
      resetN = 1'b1;
      @(negedge clock);
      check("late_rsp_no_valid", 64'(instrValid), 64'h0);
      check("late_rsp_no_req",   64'(imemReq),    64'h0);
      goto(53);

      if (req_times.size() >= 2) begin
         check("best_case_latency", 64'(req_times[1] - req_times[0]), 64'd3);
      end else begin
         n_vec++;
         n_err++;
         $display("FAIL best_case_latency: got %0d requests expected at least 2", req_times.size());
      end
      check("req_queue_empty",   64'(exp_req.size()),   64'h0);
      check("instr_queue_empty", 64'(exp_instr.size()), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
